// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-subset core: fetch and lw/sw share one req/ready memory port,
// and an FSM walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
`timescale 1ns/1ps
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] DATA_BASE  = 32'h1000_0000,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           pc,
  output logic [2:0]            state,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  retired
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ORI = 6'h0D, OP_LW  = 6'h23, OP_SW  = 6'h2B;
  localparam logic [5:0] FN_ADDU  = 6'h21, FN_SUBU = 6'h23, FN_AND = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25, FN_SLT  = 6'h2A;

  state_e                state_q, state_d;
  logic [XLEN-1:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]       aluout_q, aluout_d, mdr_q, mdr_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
  logic                  halted_q, halted_d;
  logic [CNT_WIDTH-1:0]  retired_q, retired_d;
  logic [XLEN-1:0]       gpr_q [NREG];

  logic [5:0]      opcode, funct;
  logic [4:0]      rs, rt, rd, dest;
  logic [15:0]     imm;
  logic [25:0]     target;
  logic [XLEN-1:0] imm_sext, imm_zext, alu_res, br_target, j_target, wb_data;
  logic            alu_ok, op_legal, br_taken;
  logic            retire, go_fetch, go_halt, gpr_we;

  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign funct     = ir_q[5:0];
  assign imm       = ir_q[15:0];
  assign target    = ir_q[25:0];
  assign imm_sext  = {{16{imm[15]}}, imm};
  assign imm_zext  = {16'h0000, imm};
  assign br_target = pc_q + {imm_sext[29:0], 2'b00};
  assign j_target  = {pc_q[31:28], target, 2'b00};
  assign br_taken  = (a_q == b_q) ^ (opcode == OP_BNE);
  assign dest      = (opcode == OP_RTYPE) ? rd : rt;
  assign wb_data   = (opcode == OP_LW) ? mdr_q : aluout_q;

  always_comb begin
    case (opcode)
      OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDIU, OP_ORI, OP_LW, OP_SW: op_legal = 1'b1;
      default:                                                        op_legal = 1'b0;
    endcase
  end

  // ALU; alu_ok drops for R-type functs outside the subset
  always_comb begin
    alu_res = '0;
    alu_ok  = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: alu_res = a_q + b_q;
          FN_SUBU: alu_res = a_q - b_q;
          FN_AND:  alu_res = a_q & b_q;
          FN_OR:   alu_res = a_q | b_q;
          FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
          default: alu_ok  = 1'b0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_res = a_q + imm_sext;
      OP_ORI:                 alu_res = a_q | imm_zext;
      default:                alu_res = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    aluout_d    = aluout_q;
    mdr_d       = mdr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    retired_d   = retired_q;
    retire      = 1'b0;
    go_fetch    = 1'b0;
    go_halt     = 1'b0;
    gpr_we      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q[ADDR_WIDTH-1:0];
        end else if (mem_ready) begin
          ir_d      = mem_rdata;
          pc_d      = pc_q + 32'd4;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = gpr_q[rs];
        b_d = gpr_q[rt];
        if (op_legal) state_d = S_EXEC;
        else          go_halt = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            if (alu_ok) begin
              aluout_d = alu_res;
              state_d  = S_WB;
            end else begin
              go_halt = 1'b1;
            end
          end
          OP_ADDIU, OP_ORI: begin
            aluout_d = alu_res;
            state_d  = S_WB;
          end
          OP_BEQ, OP_BNE: begin
            if (br_taken) pc_d = br_target;
            retire   = 1'b1;
            go_fetch = 1'b1;
          end
          OP_J: begin
            pc_d     = j_target;
            retire   = 1'b1;
            go_fetch = 1'b1;
          end
          OP_LW, OP_SW: begin
            aluout_d = alu_res;
            // misaligned access faults before any request leaves the core
            if (alu_res[1:0] != 2'b00) begin
              go_halt = 1'b1;
            end else begin
              state_d     = S_MEM;
              mem_req_d   = 1'b1;
              mem_we_d    = (opcode == OP_SW);
              mem_addr_d  = ADDR_WIDTH'(alu_res - DATA_BASE);
              mem_wdata_d = b_q;
            end
          end
          default: go_halt = 1'b1;
        endcase
      end
      S_MEM: begin
        if (mem_req_q && mem_ready) begin
          if (opcode == OP_SW) begin
            retire   = 1'b1;
            go_fetch = 1'b1;
          end else begin
            mdr_d     = mem_rdata;
            mem_req_d = 1'b0;
            state_d   = S_WB;
          end
        end
      end
      S_WB: begin
        gpr_we   = (dest != 5'd0);
        retire   = 1'b1;
        go_fetch = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: go_halt = 1'b1;
    endcase

    // Next fetch request goes out straight from the retiring state
    if (go_fetch) begin
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d[ADDR_WIDTH-1:0];
    end
    if (go_halt) begin
      state_d   = S_HALT;
      halted_d  = 1'b1;
      mem_req_d = 1'b0;
      mem_we_d  = 1'b0;
    end
    if (retire && (retired_q != {CNT_WIDTH{1'b1}})) retired_d = retired_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      aluout_q    <= '0;
      mdr_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      halted_q    <= 1'b0;
      retired_q   <= '0;
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      aluout_q    <= aluout_d;
      mdr_q       <= mdr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
      if (gpr_we) gpr_q[dest] <= wb_data;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = halted_q;
  assign retired   = retired_q;
endmodule
